seven_segment_scan: RTL

SEVEN_SEGMENT_SCAN -- requirements
Module: seven_segment_scan

---
 rtl/seven_segment_pkg.sv | 29 ++
 rtl/seven_segment_decoder.sv | 32 +++
 rtl/seven_segment_scan.sv | 110 +++++++++++
 3 files changed

// File: rtl/seven_segment_pkg.sv
// Shared glyphs and defaults for the multiplexed seven-segment scanner.
// Glyphs are active-low abcdefg with segment a at bit 6.
package seven_segment_pkg;

    typedef logic [6:0] seg_t;

    localparam int DIGITS_DEF   = 8;
    localparam int BRIGHT_W_DEF = 3;

    localparam seg_t SEG_OFF = 7'h7F;

    localparam seg_t SEG_0 = 7'h01;
    localparam seg_t SEG_1 = 7'h4F;
    localparam seg_t SEG_2 = 7'h12;
    localparam seg_t SEG_3 = 7'h06;
    localparam seg_t SEG_4 = 7'h4C;
    localparam seg_t SEG_5 = 7'h24;
    localparam seg_t SEG_6 = 7'h20;
    localparam seg_t SEG_7 = 7'h0F;
    localparam seg_t SEG_8 = 7'h00;
    localparam seg_t SEG_9 = 7'h04;
    localparam seg_t SEG_A = 7'h08;
    localparam seg_t SEG_B = 7'h60;
    localparam seg_t SEG_C = 7'h31;
    localparam seg_t SEG_D = 7'h42;
    localparam seg_t SEG_E = 7'h30;
    localparam seg_t SEG_F = 7'h38;

endpackage

// File: rtl/seven_segment_decoder.sv
// Hex nibble to active-low seven-segment glyph, purely combinational.
// Lowercase b and d keep them distinct from 8 and 0.
module seven_segment_decoder
    import seven_segment_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] seg
);

    always_comb begin
        seg = SEG_OFF;
        unique case (nibble)
            4'h0: seg = SEG_0;
            4'h1: seg = SEG_1;
            4'h2: seg = SEG_2;
            4'h3: seg = SEG_3;
            4'h4: seg = SEG_4;
            4'h5: seg = SEG_5;
            4'h6: seg = SEG_6;
            4'h7: seg = SEG_7;
            4'h8: seg = SEG_8;
            4'h9: seg = SEG_9;
            4'hA: seg = SEG_A;
            4'hB: seg = SEG_B;
            4'hC: seg = SEG_C;
            4'hD: seg = SEG_D;
            4'hE: seg = SEG_E;
            4'hF: seg = SEG_F;
        endcase
    end

endmodule

// File: rtl/seven_segment_scan.sv
// Multiplexed seven-segment scanner with PWM brightness and blinking.
// Define SEVEN_SEGMENT_SCAN_LZB_EN to compile in leading-zero blanking.
module seven_segment_scan
    import seven_segment_pkg::*;
#(
    parameter int DIGITS   = DIGITS_DEF,
    parameter int BRIGHT_W = BRIGHT_W_DEF
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  en,
    input  logic [4*DIGITS-1:0]   num,
    input  logic [DIGITS-1:0]     dots,
    input  logic [DIGITS-1:0]     blink,
    input  logic                  blink_phase,
    input  logic [BRIGHT_W-1:0]   brightness,
    output logic [6:0]            abcdefg,
    output logic                  dot,
    output logic [DIGITS-1:0]     anodes,
    output logic                  frame_done
);

    localparam int IDX_W = $clog2(DIGITS);

    logic [BRIGHT_W-1:0] pwm;
    logic [IDX_W-1:0]    idx;
    logic [4*DIGITS-1:0] snap_num;
    logic [DIGITS-1:0]   snap_dots;

    logic       pwm_wrap;
    logic       idx_wrap;
    logic [3:0] nib;
    logic [6:0] glyph;
    logic       lz_blank;
    logic       blink_blank;
    logic       drive;

    assign pwm_wrap = (pwm == '1);
    assign idx_wrap = pwm_wrap && (idx == IDX_W'(DIGITS - 1));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pwm       <= '0;
            idx       <= '0;
            snap_num  <= '0;
            snap_dots <= '0;
        end else if (en) begin
            pwm <= pwm + BRIGHT_W'(1);
            if (pwm_wrap) begin
                idx <= idx_wrap ? '0 : idx + IDX_W'(1);
            end
            // Frame-level snapshot keeps a scan free of tearing.
            if (idx_wrap) begin
                snap_num  <= num;
                snap_dots <= dots;
            end
        end
    end

    assign nib = snap_num[{idx, 2'b00} +: 4];

    seven_segment_decoder u_dec (
        .nibble (nib),
        .seg    (glyph)
    );

`ifdef SEVEN_SEGMENT_SCAN_LZB_EN
    logic [DIGITS-1:0] lead_zero;

    // Blank run from the top digit down; digit 0 always shows.
    always_comb begin
        logic run;
        run       = 1'b1;
        lead_zero = '0;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            run = run && (snap_num[4*i +: 4] == 4'h0) && !snap_dots[i];
            lead_zero[i] = run;
        end
        lead_zero[0] = 1'b0;
    end

    assign lz_blank = lead_zero[idx];
`else
    assign lz_blank = 1'b0;
`endif

    assign blink_blank = blink[idx] && blink_phase;
    assign drive = (pwm < brightness) && !blink_blank && !lz_blank;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            abcdefg    <= SEG_OFF;
            dot        <= 1'b1;
            anodes     <= '1;
            frame_done <= 1'b0;
        end else begin
            frame_done <= en && idx_wrap;
            if (drive) begin
                abcdefg <= glyph;
                dot     <= ~snap_dots[idx];
                anodes  <= ~(DIGITS'(1) << idx);
            end else begin
                abcdefg <= SEG_OFF;
                dot     <= 1'b1;
                anodes  <= '1;
            end
        end
    end

endmodule
